// File: rtl/stack_regfile_if.sv
// Bus bundle for stack_regfile: push/pop commands in, stack view out.
// With STACK_ERR_FLAGS_EN defined it also carries err_overflow, err_underflow and err_clear.
interface stack_regfile_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Command semantics: push and pop are single-cycle requests with no ready
  // return. Every request is consumed at the rising edge where it is high.
  // A push while full or a pop while empty is dropped without changing the
  // stack and is reported only through the error flags when they exist.
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_data;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] nos;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
`ifdef STACK_ERR_FLAGS_EN
  logic             err_overflow;
  logic             err_underflow;
  logic             err_clear;
`endif

  modport master (
    output push,
    output pop,
    output push_data,
    input  tos,
    input  nos,
    input  count,
    input  empty,
    input  full
`ifdef STACK_ERR_FLAGS_EN
    ,
    output err_clear,
    input  err_overflow,
    input  err_underflow
`endif
  );

  modport slave (
    input  push,
    input  pop,
    input  push_data,
    output tos,
    output nos,
    output count,
    output empty,
    output full
`ifdef STACK_ERR_FLAGS_EN
    ,
    input  err_clear,
    output err_overflow,
    output err_underflow
`endif
  );
endinterface

// File: rtl/stack_regfile.sv
// Register-file stack with combinational top/next-of-stack reads and push, pop and replace.
// Optional sticky overflow/underflow flags are built when STACK_ERR_FLAGS_EN is defined.
module stack_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input logic           clock,
  input logic           reset,
  stack_regfile_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  if (WIDTH < 1 || WIDTH > 32 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("stack_regfile: WIDTH must be 1..32 and DEPTH a power of two >= 2");
  end

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_OVERFLOW,
    OP_UNDERFLOW
  } op_e;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count_q;
  logic             empty_w;
  logic             full_w;
  logic [AW-1:0]    tos_idx;
  logic [AW-1:0]    nos_idx;
  logic [AW-1:0]    wr_idx;
  logic             wr_en;
  op_e              op;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));

  // Indices wrap harmlessly when count is small; the read muxes below mask them.
  assign tos_idx = AW'(count_q - CW'(1));
  assign nos_idx = AW'(count_q - CW'(2));

  always_comb begin
    op = OP_IDLE;
    case ({bus.push, bus.pop})
      2'b10:   op = full_w  ? OP_OVERFLOW  : OP_PUSH;
      2'b01:   op = empty_w ? OP_UNDERFLOW : OP_POP;
      2'b11:   op = empty_w ? OP_UNDERFLOW : OP_REPLACE;
      default: op = OP_IDLE;
    endcase
  end

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = tos_idx;
    if (!reset) begin
      if (op == OP_PUSH) begin
        wr_en  = 1'b1;
        wr_idx = AW'(count_q);
      end else if (op == OP_REPLACE) begin
        wr_en  = 1'b1;
        wr_idx = tos_idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      case (op)
        OP_PUSH: count_q <= count_q + CW'(1);
        OP_POP:  count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is deliberately left out of reset; count alone defines validity.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_idx] <= bus.push_data;
    end
  end

  assign bus.tos   = empty_w ? '0 : mem[tos_idx];
  assign bus.nos   = (count_q >= CW'(2)) ? mem[nos_idx] : '0;
  assign bus.count = count_q;
  assign bus.empty = empty_w;
  assign bus.full  = full_w;

`ifdef STACK_ERR_FLAGS_EN
  logic err_overflow_q;
  logic err_underflow_q;

  // An event in the same cycle as err_clear wins, so the flag stays set.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      if (op == OP_OVERFLOW) begin
        err_overflow_q <= 1'b1;
      end else if (bus.err_clear) begin
        err_overflow_q <= 1'b0;
      end
      if (op == OP_UNDERFLOW) begin
        err_underflow_q <= 1'b1;
      end else if (bus.err_clear) begin
        err_underflow_q <= 1'b0;
      end
    end
  end

  assign bus.err_overflow  = err_overflow_q;
  assign bus.err_underflow = err_underflow_q;
`endif
endmodule

// File: tb/tb_stack_regfile.sv
// Self-checking bench for stack_regfile: a 8x16 and a 4x4 instance driven from
// vector tables plus a randomized run against a reference stack model.
module tb_stack_regfile;
  logic clock = 1'b0;
  logic reset_a;
  logic reset_b;

  always #5 clock = ~clock;

  stack_regfile_if #(.WIDTH(8), .DEPTH(16)) bus_a ();
  stack_regfile_if #(.WIDTH(4), .DEPTH(4))  bus_b ();

  stack_regfile #(.WIDTH(8), .DEPTH(16)) u_dut_a (.clock(clock), .reset(reset_a), .bus(bus_a));
  stack_regfile #(.WIDTH(4), .DEPTH(4))  u_dut_b (.clock(clock), .reset(reset_b), .bus(bus_b));

  typedef struct {
    logic       sel;
    logic       rst;
    logic       push;
    logic       pop;
    logic       clr;
    logic [7:0] data;
    logic [4:0] e_count;
    logic [7:0] e_tos;
    logic [7:0] e_nos;
    logic       e_eo;
    logic       e_eu;
  } vec_t;

  vec_t            vecs[$];
  logic [24:0]     exp_q[$];
  int              n_checks = 0;
  int              n_fail   = 0;

  logic [7:0]      m_mem[16];
  int              m_cnt;
  logic            m_eo;
  logic            m_eu;

  function automatic vec_t mk(input logic sel, input logic rst, input logic push, input logic pop,
                              input logic clr, input logic [7:0] data, input logic [4:0] cnt,
                              input logic [7:0] tos, input logic [7:0] nos, input logic eo,
                              input logic eu);
    vec_t v;
    v.sel = sel; v.rst = rst; v.push = push; v.pop = pop; v.clr = clr; v.data = data;
    v.e_count = cnt; v.e_tos = tos; v.e_nos = nos; v.e_eo = eo; v.e_eu = eu;
    return v;
  endfunction

  // Expected output word: {count, tos, nos, empty, full, err_overflow, err_underflow}
  function automatic logic [24:0] pack_exp(input logic sel, input logic [4:0] cnt,
                                           input logic [7:0] tos, input logic [7:0] nos,
                                           input logic eo, input logic eu);
    logic e_full;
    logic f_eo;
    logic f_eu;
    e_full = sel ? (cnt == 5'd4) : (cnt == 5'd16);
`ifdef STACK_ERR_FLAGS_EN
    f_eo = eo;
    f_eu = eu;
`else
    f_eo = 1'b0 & eo;
    f_eu = 1'b0 & eu;
`endif
    return {cnt, tos, nos, (cnt == 5'd0), e_full, f_eo, f_eu};
  endfunction

  function automatic logic [24:0] actual_out(input logic sel);
    logic eo;
    logic eu;
    eo = 1'b0;
    eu = 1'b0;
    if (!sel) begin
`ifdef STACK_ERR_FLAGS_EN
      eo = bus_a.err_overflow;
      eu = bus_a.err_underflow;
`endif
      return {5'(bus_a.count), bus_a.tos, bus_a.nos, bus_a.empty, bus_a.full, eo, eu};
    end
`ifdef STACK_ERR_FLAGS_EN
    eo = bus_b.err_overflow;
    eu = bus_b.err_underflow;
`endif
    return {5'(bus_b.count), 8'(bus_b.tos), 8'(bus_b.nos), bus_b.empty, bus_b.full, eo, eu};
  endfunction

  task automatic idle_all();
    reset_a = 1'b0; reset_b = 1'b0;
    bus_a.push = 1'b0; bus_a.pop = 1'b0; bus_a.push_data = '0;
    bus_b.push = 1'b0; bus_b.pop = 1'b0; bus_b.push_data = '0;
`ifdef STACK_ERR_FLAGS_EN
    bus_a.err_clear = 1'b0;
    bus_b.err_clear = 1'b0;
`endif
  endtask

  task automatic apply(input logic sel, input logic rst, input logic push, input logic pop,
                       input logic clr, input logic [7:0] data);
    idle_all();
    if (!sel) begin
      reset_a = rst; bus_a.push = push; bus_a.pop = pop; bus_a.push_data = data;
`ifdef STACK_ERR_FLAGS_EN
      bus_a.err_clear = clr;
`endif
    end else begin
      reset_b = rst; bus_b.push = push; bus_b.pop = pop; bus_b.push_data = data[3:0];
`ifdef STACK_ERR_FLAGS_EN
      bus_b.err_clear = clr;
`endif
    end
    if (clr === 1'bx) $display("note: unknown clr");
    @(posedge clock);
    #1;
    idle_all();
  endtask

  task automatic check(input string name, input logic sel);
    logic [24:0] act;
    logic [24:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expected entry queued", name);
      return;
    end
    exp = exp_q.pop_front();
    act = actual_out(sel);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got count=%0d tos=%h nos=%h empty=%b full=%b eo=%b eu=%b, expected count=%0d tos=%h nos=%h empty=%b full=%b eo=%b eu=%b",
               name, act[24:20], act[19:12], act[11:4], act[3], act[2], act[1], act[0],
               exp[24:20], exp[19:12], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    idle_all();

    // 8x16 instance: basic push/pop, fill, overflow, replace, underflow, clear, reset mid-sequence
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h11, 1, 8'h11, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h22, 2, 8'h22, 8'h11, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h33, 3, 8'h33, 8'h22, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 2, 8'h22, 8'h11, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    for (int i = 0; i < 16; i++) begin
      vecs.push_back(mk(0, 0, 1, 0, 0, 8'(i), 5'(i + 1), 8'(i), (i > 0) ? 8'(i - 1) : 8'h00, 0, 0));
    end
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'hAA, 16, 8'h0F, 8'h0E, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 8'h0C, 16, 8'h0C, 8'h0E, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 8'h99, 0, 8'h00, 8'h00, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h05, 1, 8'h05, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h07, 2, 8'h07, 8'h05, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 8'h0C, 2, 8'h0C, 8'h05, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 1, 8'h05, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 8'h00, 0, 8'h00, 8'h00, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h01, 1, 8'h01, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h02, 2, 8'h02, 8'h01, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h03, 3, 8'h03, 8'h02, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'h55, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h44, 1, 8'h44, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1, 8'h44, 8'h00, 0, 0));

    // 4x4 instance: same flows scaled down, saturation at 4
    vecs.push_back(mk(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 8'h01, 1, 8'h01, 8'h00, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 8'h02, 2, 8'h02, 8'h01, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 8'h03, 3, 8'h03, 8'h02, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 8'h00, 2, 8'h02, 8'h01, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0));
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(mk(1, 0, 1, 0, 0, 8'(i), 5'(i + 1), 8'(i), (i > 0) ? 8'(i - 1) : 8'h00, 0, 0));
    end
    vecs.push_back(mk(1, 0, 1, 0, 0, 8'h0A, 4, 8'h03, 8'h02, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0, 8'h09, 4, 8'h09, 8'h02, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 8'h00, 3, 8'h02, 8'h01, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 8'h00, 2, 8'h01, 8'h00, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 8'h00, 1, 8'h00, 8'h00, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 1, 1));

    foreach (vecs[k]) begin
      exp_q.push_back(pack_exp(vecs[k].sel, vecs[k].e_count, vecs[k].e_tos, vecs[k].e_nos,
                               vecs[k].e_eo, vecs[k].e_eu));
      apply(vecs[k].sel, vecs[k].rst, vecs[k].push, vecs[k].pop, vecs[k].clr, vecs[k].data);
      check($sformatf("vec%0d", k), vecs[k].sel);
    end

    // Randomized run on the 8x16 instance: fill bias first, then drain bias
    m_cnt = 0; m_eo = 1'b0; m_eu = 1'b0;
    exp_q.push_back(pack_exp(0, 0, 8'h00, 8'h00, 0, 0));
    apply(0, 1, 0, 0, 0, 8'h00);
    check("rand_reset", 0);
    for (int i = 0; i < 400; i++) begin
      logic       rst, push, pop, clr, ev_o, ev_u;
      logic [7:0] d;
      rst  = ($urandom_range(0, 79) == 0);
      push = (i < 200) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 2) == 0);
      pop  = (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      clr  = ($urandom_range(0, 15) == 0);
      d    = 8'($urandom_range(0, 255));
      ev_o = 1'b0;
      ev_u = 1'b0;
      if (rst) begin
        m_cnt = 0; m_eo = 1'b0; m_eu = 1'b0;
      end else begin
        if (push && !pop) begin
          if (m_cnt == 16) ev_o = 1'b1;
          else begin m_mem[m_cnt] = d; m_cnt++; end
        end else if (pop && !push) begin
          if (m_cnt == 0) ev_u = 1'b1;
          else m_cnt--;
        end else if (push && pop) begin
          if (m_cnt == 0) ev_u = 1'b1;
          else m_mem[m_cnt - 1] = d;
        end
        if (clr) begin m_eo = 1'b0; m_eu = 1'b0; end
        if (ev_o) m_eo = 1'b1;
        if (ev_u) m_eu = 1'b1;
      end
      exp_q.push_back(pack_exp(0, 5'(m_cnt), (m_cnt >= 1) ? m_mem[m_cnt - 1] : 8'h00,
                               (m_cnt >= 2) ? m_mem[m_cnt - 2] : 8'h00, m_eo, m_eu));
      apply(0, rst, push, pop, clr, d);
      check($sformatf("rand%0d", i), 0);
    end

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expected: got %0d entries, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stack_regfile.md
STACK_REGFILE -- requirements
Module: stack_regfile

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, legal range 1..32.
REQ-002 Parameter DEPTH, default 16: stack capacity in words; power of two, at least 2.
REQ-003 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port push, input, 1 bit: push request this cycle.
REQ-006 Port pop, input, 1 bit: pop request this cycle.
REQ-007 Port push_data, input, WIDTH bits: word written by push or replace.
REQ-008 Port tos, output, WIDTH bits: top-of-stack word, combinational from stored state.
REQ-009 Port nos, output, WIDTH bits: next-of-stack word (one below top), combinational.
REQ-010 Port count, output, $clog2(DEPTH)+1 bits: number of valid entries, 0..DEPTH.
REQ-011 Port empty, output, 1 bit: high iff count==0.
REQ-012 Port full, output, 1 bit: high iff count==DEPTH.
REQ-013 Ports err_overflow, err_underflow, err_clear exist only per REQ-030.

Function
REQ-014 Storage shall be DEPTH x WIDTH registers; entry i holds the word at stack position i (0 = bottom).
REQ-015 Push only, not full: mem[count] <= push_data; count <= count+1.
REQ-016 Push only, full: no storage or count change; overflow event.
REQ-017 Pop only, count>=1: count <= count-1; storage unchanged.
REQ-018 Pop only, empty: no state change; underflow event.
REQ-019 Push and pop together, count>=1 (replace): mem[count-1] <= push_data; count unchanged; legal when full.
REQ-020 Push and pop together, empty: no state change; underflow event.
REQ-021 Neither asserted: no state change.
REQ-022 tos shall equal mem[count-1] when count>=1, else all zeros.
REQ-023 nos shall equal mem[count-2] when count>=2, else all zeros.
REQ-024 Latency: an accepted push or replace shall be visible on tos in the cycle after the edge that performs it; pop likewise.
REQ-025 count shall never wrap: it stays within 0..DEPTH under any input sequence.
REQ-026 Entries at positions >= count shall never affect tos or nos.

Reset
REQ-027 While reset is high at a rising edge, count <= 0 and all error flags <= 0, overriding push, pop and err_clear.
REQ-028 Storage shall not be reset; tos and nos shall read zero after reset per REQ-022/REQ-023.
REQ-029 Reset asserted mid-sequence shall discard the stack in one cycle; the next accepted push lands at position 0.

Configuration
REQ-030 Macro STACK_ERR_FLAGS_EN defined: add output err_overflow (1 bit), output err_underflow (1 bit) and input err_clear (1 bit).
REQ-031 With the macro, err_overflow is set by an overflow event and err_underflow by an underflow event; both are sticky until err_clear or reset.
REQ-032 With the macro, err_clear high at an edge clears both flags; an event in the same cycle wins, and its flag reads 1 afterwards.
REQ-033 Without the macro: the three ports and their flag state are absent; overflow and underflow events are silently ignored, with data behaviour unchanged.

Verification
REQ-034 After reset, push 0x11, 0x22, 0x33 on consecutive cycles -> count=3, tos=0x33, nos=0x22; pop -> tos=0x22, nos=0x11, count=2.
REQ-035 Push 16 words 0x00..0x0F (DEPTH=16), then push 0xAA -> full=1, count=16, tos=0x0F, err_overflow=1 (macro defined).
REQ-036 From empty: pop, then push+pop together -> count stays 0, tos=0, nos=0, err_underflow=1; err_clear -> flag 0 the next cycle.
REQ-037 With stack [0x05,0x07]: push+pop with push_data 0x0C -> count=2, tos=0x0C, nos=0x05; repeat when full -> count stays 16, full stays 1.
REQ-038 Push 3 words, assert reset for one cycle alongside push -> count=0, empty=1, tos=0; then push 0x44 -> count=1, tos=0x44, nos=0.
REQ-039 Rerun REQ-034 and REQ-035 with WIDTH=4, DEPTH=4 and the macro undefined -> count saturates at 4, no error ports, data matches the expected stack model.
